point_word_deserializer: RTL
============================

POINT_WORD_DESERIALIZER -- requirements
Module: point_word_deserializer

Interface
REQ-001 SHALL have parameter P_WIDTH, default 256, coordinate width; matches the curve package P_WIDTH.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, input word width; P_WIDTH SHALL be an integer multiple of WORD_WIDTH (NW = P_WIDTH/WORD_WIDTH, default 8).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_word  input  WORD_WIDTH  serialized coordinate word.
REQ-007 in_valid  input  1  in_word/in_last valid.
REQ-008 in_last  input  1  marks final word of a frame.
REQ-009 in_ready  output  1  block accepts a word this cycle.
REQ-010 point_out  output  2*P_WIDTH  assembled point, curve_point_t layout (x in upper half, y in lower half).
REQ-011 point_valid  output  1  point_out valid.
REQ-012 point_ready  input  1  downstream accepts point_out.
REQ-013 range_err  output  1  qualified by point_valid; x >= params.p or y >= params.p.
REQ-014 is_inf  output  1  qualified by point_valid; point equals inf_point (x=0, y=0).
REQ-015 frame_err  output  1  one-cycle pulse on malformed frame.

Function
REQ-016 A word SHALL be accepted on a rising edge with in_valid && in_ready.
REQ-017 Frame SHALL be 2*NW words: x then y, each coordinate most-significant word first.
REQ-018 States SHALL be COLLECT_X, COLLECT_Y, OUTPUT, DRAIN; word counter 0..NW-1 wraps to 0 on X->Y transition.
REQ-019 in_ready SHALL be 1 in COLLECT_X, COLLECT_Y, DRAIN; 0 in OUTPUT.
REQ-020 COLLECT_X: NW-th accepted word -> COLLECT_Y; COLLECT_Y: NW-th accepted word with in_last=1 -> OUTPUT.
REQ-021 Accepted word with in_last=1 before frame word 2*NW SHALL pulse frame_err next cycle, discard partial data, -> COLLECT_X, counter 0.
REQ-022 Frame word 2*NW accepted with in_last=0 SHALL pulse frame_err, discard data, -> DRAIN.
REQ-023 DRAIN SHALL accept and discard words; accepted word with in_last=1 -> COLLECT_X.
REQ-024 point_valid SHALL rise the cycle after final word acceptance (latency 1); range_err and is_inf SHALL be registered with it.
REQ-025 point_out, range_err, is_inf SHALL hold stable while point_valid && !point_ready.
REQ-026 On point_valid && point_ready: point_valid deasserts next cycle, state -> COLLECT_X; minimum period 2*NW+1 cycles per point.
REQ-027 Range compare SHALL be full-width unsigned against params.p; x == p counts as error.
REQ-028 Input words presented while in_ready=0 SHALL be ignored (not consumed).

Reset
REQ-029 reset_n low SHALL immediately force: state COLLECT_X, counter 0, in_ready 0, point_valid 0, range_err 0, is_inf 0, frame_err 0, point_out 0.
REQ-030 in_ready SHALL be 1 from the first clock edge after reset_n deasserts.
REQ-031 Reset mid-frame or mid-OUTPUT SHALL discard all state; no point emitted for the interrupted frame.

Verification
REQ-032 secp256k1 G (x=79BE667E...16F81798, y=483ADA77...FB10D4B8) sent as 16 words, in_last on word 16, point_ready=1 -> point_valid one cycle later, point_out=G, range_err=0, is_inf=0.
REQ-033 Same frame with point_ready=0 for 5 cycles -> point_out stable, in_ready=0 throughout, in_valid words ignored; release -> next frame accepted correctly.
REQ-034 in_last on word 9 -> frame_err pulse, no point_valid; following valid G frame -> point_out=G.
REQ-035 16 words without in_last then 3 words ending in_last -> frame_err once, DRAIN consumes 3, next frame decodes correctly.
REQ-036 x = params.p, y = 0 -> range_err=1; all-zero frame -> is_inf=1, range_err=0.
REQ-037 reset_n pulsed low after word 10 -> outputs zero asynchronously; subsequent full G frame -> point_out=G.

Source files
------------

// File: rtl/point_word_deserializer.sv
// point_word_deserializer: assembles a serialized (x,y) curve point from words with framing and range checks
module point_word_deserializer #(
  parameter int P_WIDTH = 256,
  parameter int WORD_WIDTH = 32,
  parameter logic [P_WIDTH-1:0] P_MOD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WORD_WIDTH-1:0]  in_word,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [2*P_WIDTH-1:0]   point_out,
  output logic                   point_valid,
  input  logic                   point_ready,
  output logic                   range_err,
  output logic                   is_inf,
  output logic                   frame_err
);
  localparam int NW = P_WIDTH / WORD_WIDTH;
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  typedef enum logic [1:0] {COLLECT_X, COLLECT_Y, OUTPUT, DRAIN} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q, slot;
  logic [P_WIDTH-1:0] x_q, y_q, y_d;
  logic in_ready_q, point_valid_q, range_err_q, is_inf_q, frame_err_q;
  logic accept, last_cnt;
  assign accept = in_valid && in_ready_q;
  assign last_cnt = cnt_q == CW'(NW - 1);
  assign slot = CW'(NW - 1) - cnt_q;
  assign in_ready = in_ready_q;
  assign point_valid = point_valid_q;
  assign range_err = range_err_q;
  assign is_inf = is_inf_q;
  assign frame_err = frame_err_q;
  assign point_out = {x_q, y_q};
  // y with the incoming word placed, so the checks see the complete coordinate on the final word
  always_comb begin
    y_d = y_q;
    y_d[slot*WORD_WIDTH +: WORD_WIDTH] = in_word;
  end
  // frame parser: collect x then y (MSW first), validate framing, present point until taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT_X;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      in_ready_q <= 1'b0;
      point_valid_q <= 1'b0;
      range_err_q <= 1'b0;
      is_inf_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      in_ready_q <= 1'b1;
      frame_err_q <= 1'b0;
      case (state_q)
        COLLECT_X: if (accept) begin
          if (in_last) begin
            frame_err_q <= 1'b1;
            cnt_q <= '0;
            x_q <= '0;
          end else begin
            x_q[slot*WORD_WIDTH +: WORD_WIDTH] <= in_word;
            cnt_q <= last_cnt ? '0 : cnt_q + 1'b1;
            state_q <= last_cnt ? COLLECT_Y : COLLECT_X;
          end
        end
        COLLECT_Y: if (accept) begin
          if (last_cnt && in_last) begin
            y_q <= y_d;
            cnt_q <= '0;
            state_q <= OUTPUT;
            in_ready_q <= 1'b0;
            point_valid_q <= 1'b1;
            range_err_q <= (x_q >= P_MOD) || (y_d >= P_MOD);
            is_inf_q <= ~|x_q && ~|y_d;
          end else if (last_cnt || in_last) begin
            frame_err_q <= 1'b1;
            cnt_q <= '0;
            x_q <= '0;
            y_q <= '0;
            state_q <= in_last ? COLLECT_X : DRAIN;
          end else begin
            y_q <= y_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        OUTPUT: begin
          in_ready_q <= point_ready;
          if (point_ready) begin
            point_valid_q <= 1'b0;
            range_err_q <= 1'b0;
            is_inf_q <= 1'b0;
            state_q <= COLLECT_X;
          end
        end
        DRAIN: if (accept && in_last) state_q <= COLLECT_X;
        default: state_q <= COLLECT_X;
      endcase
    end
  end
endmodule
